// File: rtl/ps2_dir_decoder.sv
// ps2_dir_decoder: receives PS/2 set-2 frames, reports key events and holds arrow/WASD direction levels.
module ps2_dir_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] dir_p0,
    output logic [3:0] dir_p1,
    output logic       key_valid,
    output logic [8:0] key_code,
    output logic       key_break,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_s_q, dat_s_q;
    logic            clk_prev_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic            ok_q, ok_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            bv_q, bv_d, fe_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic            fall, din, is_key;
    logic [8:0]      code;
    logic [3:0]      m0, m1, dir_p0_d, dir_p1_d;

    assign fall = clk_prev_q & ~clk_s_q[1];
    assign din  = dat_s_q[1];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        ok_d      = ok_q;
        bv_d      = 1'b0;
        fe_d      = 1'b0;
        tcnt_d    = (fall || state_q == IDLE) ? '0 : tcnt_q + 1'b1;
        if (fall) begin
            case (state_q)
                IDLE: if (!din) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
                DATA: begin
                    sh_d      = {din, sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    ok_d    = ^{sh_q, din};
                    state_d = STOP;
                end
                default: begin
                    bv_d    = din & ok_q;
                    fe_d    = ~(din & ok_q);
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE && tcnt_q == TMAX) begin
            state_d = IDLE;
            fe_d    = 1'b1;
        end
    end

    // Byte layer: prefixes arm ext/brk, any other byte is a key event.
    assign code   = {ext_q, sh_q};
    assign is_key = bv_q && sh_q != 8'hE0 && sh_q != 8'hF0;
    assign m0 = {code == 9'h175, code == 9'h172, code == 9'h16B, code == 9'h174};
    assign m1 = {code == 9'h01D, code == 9'h01B, code == 9'h01C, code == 9'h023};

    always_comb begin
        ext_d    = (frame_err || is_key) ? 1'b0 : (bv_q && sh_q == 8'hE0) ? 1'b1 : ext_q;
        brk_d    = (frame_err || is_key) ? 1'b0 : (bv_q && sh_q == 8'hF0) ? 1'b1 : brk_q;
        dir_p0_d = !is_key ? dir_p0 : brk_q ? (dir_p0 & ~m0) : (dir_p0 | m0);
        dir_p1_d = !is_key ? dir_p1 : brk_q ? (dir_p1 & ~m1) : (dir_p1 | m1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            ok_q       <= 1'b0;
            tcnt_q     <= '0;
            bv_q       <= 1'b0;
            frame_err  <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_break  <= 1'b0;
            dir_p0     <= '0;
            dir_p1     <= '0;
        end else begin
            clk_s_q    <= {clk_s_q[0], ps2_clk};
            dat_s_q    <= {dat_s_q[0], ps2_data};
            clk_prev_q <= clk_s_q[1];
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            ok_q       <= ok_d;
            tcnt_q     <= tcnt_d;
            bv_q       <= bv_d;
            frame_err  <= fe_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_valid  <= is_key;
            key_code   <= is_key ? code : key_code;
            key_break  <= is_key ? brk_q : key_break;
            dir_p0     <= dir_p0_d;
            dir_p1     <= dir_p1_d;
        end
    end
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// tb_ps2_dir_decoder: table-driven PS/2 frame vectors plus timeout, reset and latency sequences.
module tb_ps2_dir_decoder;
    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [3:0] dir_p0, dir_p1;
    logic       key_valid, key_break, frame_err;
    logic [8:0] key_code;
    int         total = 0, bad = 0, kv_n = 0, fe_n = 0;
    logic [8:0] kv_code;
    logic       kv_brk;

    ps2_dir_decoder #(.TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .dir_p0(dir_p0), .dir_p1(dir_p1), .key_valid(key_valid),
        .key_code(key_code), .key_break(key_break), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            kv_n++;
            kv_code = key_code;
            kv_brk  = key_break;
        end
        if (!rst && frame_err) fe_n++;
    end

    typedef struct {
        logic [7:0] b;
        logic       bad_par;
        logic       stop;
        logic [3:0] p0;
        logic [3:0] p1;
        int         kv;
        int         fe;
        logic [8:0] code;
        logic       brk;
    } vec_t;

    vec_t v[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        #1 ps2_data = 1'b1;
    endtask

    initial begin
        int kv0, fe0, first;
        v[0]  = '{8'h1D, 0, 1, 4'h0, 4'h8, 1, 0, 9'h01D, 0};
        v[1]  = '{8'hE0, 0, 1, 4'h0, 4'h8, 0, 0, 9'h000, 0};
        v[2]  = '{8'h75, 0, 1, 4'h8, 4'h8, 1, 0, 9'h175, 0};
        v[3]  = '{8'hE0, 0, 1, 4'h8, 4'h8, 0, 0, 9'h000, 0};
        v[4]  = '{8'hF0, 0, 1, 4'h8, 4'h8, 0, 0, 9'h000, 0};
        v[5]  = '{8'h75, 0, 1, 4'h0, 4'h8, 1, 0, 9'h175, 1};
        v[6]  = '{8'h1C, 1, 1, 4'h0, 4'h8, 0, 1, 9'h000, 0};
        v[7]  = '{8'h1D, 0, 1, 4'h0, 4'h8, 1, 0, 9'h01D, 0};
        v[8]  = '{8'h23, 0, 1, 4'h0, 4'h9, 1, 0, 9'h023, 0};
        v[9]  = '{8'hF0, 0, 1, 4'h0, 4'h9, 0, 0, 9'h000, 0};
        v[10] = '{8'h1D, 0, 1, 4'h0, 4'h1, 1, 0, 9'h01D, 1};
        v[11] = '{8'h74, 0, 1, 4'h0, 4'h1, 1, 0, 9'h074, 0};
        v[12] = '{8'hE0, 0, 1, 4'h0, 4'h1, 0, 0, 9'h000, 0};
        v[13] = '{8'h6B, 0, 1, 4'h2, 4'h1, 1, 0, 9'h16B, 0};
        v[14] = '{8'hE0, 0, 1, 4'h2, 4'h1, 0, 0, 9'h000, 0};
        v[15] = '{8'h74, 0, 1, 4'h3, 4'h1, 1, 0, 9'h174, 0};
        v[16] = '{8'h1B, 0, 0, 4'h3, 4'h1, 0, 1, 9'h000, 0};
        v[17] = '{8'hE0, 0, 1, 4'h3, 4'h1, 0, 0, 9'h000, 0};
        v[18] = '{8'h75, 1, 1, 4'h3, 4'h1, 0, 1, 9'h000, 0};
        v[19] = '{8'h75, 0, 1, 4'h3, 4'h1, 1, 0, 9'h075, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_p0", dir_p0, 0);
        chk("rst_p1", dir_p1, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_brk", key_break, 0);
        chk("rst_fe", frame_err, 0);

        for (int i = 0; i < 20; i++) begin
            kv0 = kv_n;
            fe0 = fe_n;
            send(v[i].b, v[i].bad_par, v[i].stop, 11);
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_p0", i), dir_p0, v[i].p0);
            chk($sformatf("v%0d_p1", i), dir_p1, v[i].p1);
            chk($sformatf("v%0d_kv", i), kv_n - kv0, v[i].kv);
            chk($sformatf("v%0d_fe", i), fe_n - fe0, v[i].fe);
            if (v[i].kv > 0) begin
                chk($sformatf("v%0d_code", i), kv_code, v[i].code);
                chk($sformatf("v%0d_brk", i), kv_brk, v[i].brk);
                chk($sformatf("v%0d_hold", i), key_code, v[i].code);
            end
        end

        // Timeout: release D, stall after 4 data bits, then a full D make.
        send(8'hF0, 0, 1, 11);
        send(8'h23, 0, 1, 11);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("to_rel_p1", dir_p1, 4'h0);
        kv0 = kv_n;
        fe0 = fe_n;
        first = 0;
        send(8'h23, 0, 1, 5);
        for (int k = 1; k <= 250; k++) begin
            @(posedge clk);
            #1 if (frame_err && first == 0) first = k;
        end
        chk("to_fe_cnt", fe_n - fe0, 1);
        chk("to_fe_time", (first >= 180 && first <= 200), 1);
        chk("to_kv", kv_n - kv0, 0);
        send(8'h23, 0, 1, 11);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("to_p1", dir_p1, 4'h1);
        chk("to_code", kv_code, 9'h023);

        // Reset mid-frame after an E0 prefix.
        send(8'hE0, 0, 1, 11);
        send(8'h75, 0, 1, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_p0", dir_p0, 0);
        chk("mr_p1", dir_p1, 0);
        chk("mr_code", key_code, 0);
        chk("mr_kv", key_valid, 0);
        kv0 = kv_n;
        send(8'h75, 0, 1, 11);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mr_kv_n", kv_n - kv0, 1);
        chk("mr_code2", kv_code, 9'h075);
        chk("mr_p0b", dir_p0, 0);

        // Latency: key_valid and dir visible on the 4th clock after the stop-bit fall is driven.
        send(8'h1C, 0, 1, 10);
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 if (key_valid && first == 0) begin
                first = k;
                chk("lat_p1", dir_p1, 4'h2);
                chk("lat_code", key_code, 9'h01C);
            end
        end
        chk("lat_cycles", first, 4);
        #1 ps2_clk = 1'b1;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
